// File: rtl/matcher_pkg.sv
// Types and constants shared by the matcher front end: loader FSM states,
// the null terminator, the default delimiter and the word capacity helper.
package matcher_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DROP  = 2'd1,
    TERM  = 2'd2,
    READY = 2'd3
  } loader_state_e;

  localparam logic [7:0] NULL_CHAR     = '0;
  localparam logic [7:0] DEFAULT_DELIM = 8'h20;

  // Longest storable word; one SRAM slot is always kept for the terminator.
  function automatic int MAX_CHARS(input int aw);
    return (2 ** aw) - 1;
  endfunction

endpackage

// File: rtl/word_loader.sv
// Splits an incoming byte stream into delimiter-separated words and writes
// each one, null-terminated from address 0, into the matcher's word SRAM.
module word_loader
  import matcher_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] DELIM      = DATA_WIDTH'(DEFAULT_DELIM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] char_in,
  input  logic                  char_valid,
  input  logic                  char_last,
  output logic                  char_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  word_valid,
  output logic [ADDR_WIDTH-1:0] word_len,
  output logic                  word_trunc,
  input  logic                  match_done
);

  localparam logic [ADDR_WIDTH-1:0] MAX = ADDR_WIDTH'(MAX_CHARS(ADDR_WIDTH));

  function automatic logic is_delim(input logic [DATA_WIDTH-1:0] c);
    return (c == DELIM) || (c == DATA_WIDTH'(NULL_CHAR));
  endfunction

  loader_state_e         state;
  logic [ADDR_WIDTH-1:0] count;
  logic                  trunc_r;
  logic                  accept;

  logic                  wr_en_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [DATA_WIDTH-1:0] data_p1;

  assign char_ready = (state == FILL) || (state == DROP);
  assign accept     = char_valid && char_ready;

  // Stage p0 -> p1: accepted characters become a registered SRAM write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FILL;
      count    <= '0;
      trunc_r  <= 1'b0;
      wr_en_p1 <= 1'b0;
    end else begin
      wr_en_p1 <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            if (is_delim(char_in)) begin
              if (count != '0) state <= TERM;
            end else if (count != MAX) begin
              wr_en_p1 <= 1'b1;
              count    <= count + 1'b1;
              if (char_last) state <= TERM;
            end else begin
              trunc_r <= 1'b1;
              state   <= char_last ? TERM : DROP;
            end
          end
        end
        DROP: begin
          if (accept && (is_delim(char_in) || char_last)) state <= TERM;
        end
        TERM: begin
          // A word ended by char_last still has its final character in flight.
          if (!wr_en_p1) state <= READY;
        end
        READY: begin
          if (match_done) begin
            count   <= '0;
            trunc_r <= 1'b0;
            state   <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    addr_p1 <= count;
    data_p1 <= char_in;
  end

  // Stage p1 -> SRAM: character writes take priority over the terminator.
  always_comb begin
    wr_en   = wr_en_p1 || (state == TERM);
    wr_addr = count;
    wr_data = DATA_WIDTH'(NULL_CHAR);
    if (wr_en_p1) begin
      wr_addr = addr_p1;
      wr_data = data_p1;
    end
  end

  assign word_valid = (state == READY);
  assign word_len   = count;
  assign word_trunc = trunc_r;

endmodule
